// File: rtl/pythag_leg_solver.sv
// Solves b = isqrt(c*c - a*a) with a bit-serial square root, one root bit per cycle.
// Define PYTHAG_LEG_ROUND_EN to round the result to nearest instead of flooring it.
module pythag_leg_solver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] hyp,
   input  logic [7:0] leg,
   output logic       busy,
   output logic       done,
   output logic [7:0] leg_out,
   output logic       err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SQUARE = 2'd1;
   localparam logic [1:0] ROOT   = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [7:0]  hyp_q, hyp_d, leg_q, leg_d;
   logic [15:0] rad_q, rad_d;
   logic [11:0] rem_q, rem_d;
   logic [7:0]  root_q, root_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  leg_out_q, leg_out_d;
   logic        err_q, err_d;

   logic [15:0] csq, asq;
   logic [11:0] rem_sh, trial, rem_nx;
   logic [7:0]  root_nx, result;
   logic        ge;

   assign csq = {8'd0, hyp_q} * {8'd0, hyp_q};
   assign asq = {8'd0, leg_q} * {8'd0, leg_q};

   // Remainder stays <= 2*root, so 12 bits cover the shifted value with room to spare.
   assign rem_sh  = (rem_q << 2) | {10'd0, rad_q[15:14]};
   assign trial   = {2'b00, root_q, 2'b01};
   assign ge      = (rem_sh >= trial);
   assign rem_nx  = ge ? (rem_sh - trial) : rem_sh;
   assign root_nx = {root_q[6:0], ge};

`ifdef PYTHAG_LEG_ROUND_EN
   // Radicand <= 65025 keeps root_nx below 255 whenever rounding up applies.
   assign result = (rem_nx > {4'd0, root_nx}) ? (root_nx + 8'd1) : root_nx;
`else
   assign result = root_nx;
`endif

   always_comb begin
      state_d   = state_q;
      hyp_d     = hyp_q;
      leg_d     = leg_q;
      rad_d     = rad_q;
      rem_d     = rem_q;
      root_d    = root_q;
      cnt_d     = cnt_q;
      leg_out_d = leg_out_q;
      err_d     = err_q;
      case (state_q)
         SQUARE: begin
            if (leg_q > hyp_q) begin
               leg_out_d = 8'd0;
               err_d     = 1'b1;
               state_d   = DONE;
            end else begin
               rad_d   = csq - asq;
               rem_d   = 12'd0;
               root_d  = 8'd0;
               cnt_d   = 3'd0;
               err_d   = 1'b0;
               state_d = ROOT;
            end
         end
         ROOT: begin
            rem_d  = rem_nx;
            root_d = root_nx;
            rad_d  = rad_q << 2;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               leg_out_d = result;
               state_d   = DONE;
            end
         end
         default: begin
            if (start) begin
               hyp_d   = hyp;
               leg_d   = leg;
               state_d = SQUARE;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hyp_q     <= 8'd0;
         leg_q     <= 8'd0;
         rad_q     <= 16'd0;
         rem_q     <= 12'd0;
         root_q    <= 8'd0;
         cnt_q     <= 3'd0;
         leg_out_q <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hyp_q     <= hyp_d;
         leg_q     <= leg_d;
         rad_q     <= rad_d;
         rem_q     <= rem_d;
         root_q    <= root_d;
         cnt_q     <= cnt_d;
         leg_out_q <= leg_out_d;
         err_q     <= err_d;
      end
   end

   assign busy    = (state_q == SQUARE) || (state_q == ROOT);
   assign done    = (state_q == DONE);
   assign leg_out = leg_out_q;
   assign err     = err_q;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Directed bench for pythag_leg_solver: per-cycle compare against a transaction-level model
// plus literal expectations per request.
module tb_pythag_leg_solver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] hyp, leg;
   logic       busy, done, err;
   logic [7:0] leg_out;

   int total = 0;
   int bad   = 0;

   // model state: edges remaining until the result appears, and visible outputs
   int         m_left;
   bit         m_done, m_err, m_perr;
   logic [7:0] m_leg, m_pleg;

   pythag_leg_solver dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hyp(hyp), .leg(leg),
      .busy(busy), .done(done), .leg_out(leg_out), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_root(input int x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
`ifdef PYTHAG_LEG_ROUND_EN
      if (x - r * r > r) r++;
`endif
      return r[7:0];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_left = 0; m_done = 0; m_err = 0; m_perr = 0; m_leg = 0; m_pleg = 0;
   endtask

   // one clock: advance the model on the rising edge, compare on the falling edge
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (m_left == 0) begin
         m_done = 0;
         if (start) begin
            if (leg > hyp) begin
               m_left = 1; m_pleg = 0; m_perr = 1;
            end else begin
               m_left = 9; m_perr = 0;
               m_pleg = ref_root(int'(hyp) * int'(hyp) - int'(leg) * int'(leg));
            end
         end
      end else begin
         m_left--;
         if (m_left == 8) m_err = 0;
         if (m_left == 0) begin
            m_done = 1; m_leg = m_pleg; m_err = m_perr;
         end
      end
      @(negedge clk);
      chk("busy", int'(busy), int'(m_left > 0));
      chk("done", int'(done), int'(m_done));
      chk("leg_out", int'(leg_out), int'(m_leg));
      chk("err", int'(err), int'(m_err));
   endtask

   task automatic run(input int h, input int l, input int exp_leg, input int exp_err,
                      input int exp_lat);
      int n;
      hyp = h[7:0]; leg = l[7:0]; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("done_seen(%0d,%0d)", h, l), int'(done), 1);
      chk($sformatf("latency(%0d,%0d)", h, l), n, exp_lat);
      chk($sformatf("leg_out(%0d,%0d)", h, l), int'(leg_out), exp_leg);
      chk($sformatf("err(%0d,%0d)", h, l), int'(err), exp_err);
   endtask

   initial begin
      int dcnt;
      int r91, r351;
`ifdef PYTHAG_LEG_ROUND_EN
      r91 = 10; r351 = 19;
`else
      r91 = 9;  r351 = 18;
`endif
      model_reset();
      rst_n = 1'b0; start = 1'b0; hyp = 8'd0; leg = 8'd0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_leg_out", int'(leg_out), 0);
      chk("rst_err", int'(err), 0);
      tick(); tick();
      rst_n = 1'b1;

      run(5, 3, 4, 0, 9);
      run(10, 3, r91, 0, 9);
      run(255, 0, 255, 0, 9);
      run(200, 200, 0, 0, 9);
      run(3, 5, 0, 1, 1);
      run(13, 12, 5, 0, 9);
      run(0, 0, 0, 0, 9);
      run(20, 7, r351, 0, 9);
      run(9, 8, 4, 0, 9);
      run(100, 60, 80, 0, 9);
      tick(); tick();

      // reset during ROOT: abort, no done afterwards
      hyp = 8'd13; leg = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_leg_out", int'(leg_out), 0);
      chk("midrst_err", int'(err), 0);
      tick(); tick();
      rst_n = 1'b1;
      dcnt = 0;
      repeat (15) begin
         tick();
         if (done) dcnt++;
      end
      chk("no_done_after_rst", dcnt, 0);
      run(13, 5, 12, 0, 9);

      // start held high: operands latched once, re-accepted straight from DONE
      hyp = 8'd13; leg = 8'd12; start = 1'b1;
      tick();
      hyp = 8'd255; leg = 8'd0;
      repeat (9) tick();
      chk("held_done1", int'(done), 1);
      chk("held_leg1", int'(leg_out), 5);
      repeat (9) tick();
      chk("held_busy2", int'(busy), 1);
      tick();
      chk("held_done2", int'(done), 1);
      chk("held_leg2", int'(leg_out), 255);
      start = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
